// File: rtl/spi_txn_arbiter_if.sv
// Bus bundle between the requester-facing / SPI-register-facing logic and spi_txn_arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding logic.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]        req_pi;
    logic [NUM_REQ*ADDR_W-1:0] n_tx_end_pi;
    logic [NUM_REQ*DW-1:0]     wdata_pi;
    logic [NUM_REQ-1:0]        wd_ack_po;
    logic [NUM_REQ-1:0]        gnt_po;
    logic [DW-1:0]             rdata_po;
    logic [NUM_REQ-1:0]        rvalid_po;
    logic [NUM_REQ-1:0]        done_po;
    logic [NUM_REQ-1:0]        err_po;
    logic                      busy_po;
    logic                      spi_wr_po;
    logic                      spi_reg_sel_po;
    logic [ADDR_W-1:0]         spi_addr_po;
    logic [DW-1:0]             spi_entrada_po;
    logic [DW-1:0]             spi_salida_pi;

    modport master (
        input  req_pi, n_tx_end_pi, wdata_pi, spi_salida_pi,
        output wd_ack_po, gnt_po, rdata_po, rvalid_po, done_po, err_po, busy_po,
               spi_wr_po, spi_reg_sel_po, spi_addr_po, spi_entrada_po
    );

    modport slave (
        output req_pi, n_tx_end_pi, wdata_pi, spi_salida_pi,
        input  wd_ack_po, gnt_po, rdata_po, rvalid_po, done_po, err_po, busy_po,
               spi_wr_po, spi_reg_sel_po, spi_addr_po, spi_entrada_po
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that sequences a full SPI transaction (load TX words, kick the
// control register, poll send, read RX words back) on behalf of one requester at a time.
module spi_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk_pi,
    input  logic               rst_n_pi,
    spi_txn_arbiter_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CTRL, S_WAIT, S_READ, S_DONE, S_ABORT, S_ERR
    } state_t;

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [GW:0]        NR_W     = (GW+1)'(NUM_REQ);
    localparam logic [CW-1:0]      CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [TW-1:0]      TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]      TMO_LIM  = TW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_R    = {{(NUM_REQ-1){1'b0}}, 1'b1};

    function automatic logic [DW-1:0] ctrl_word(input logic [ADDR_W-1:0] n);
        logic [DW-1:0] w;
        w             = '0;
        w[ADDR_W+3:4] = n;
        w[0]          = 1'b1;
        return w;
    endfunction

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d, g_q, g_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, wd_ack_q, wd_ack_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
    logic                busy_q, busy_d, spi_wr_q, spi_wr_d, reg_sel_q, reg_sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DW-1:0]       entrada_q, entrada_d, rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  req_rot_s;
    logic [GW-1:0]       off_s, win_s, next_g_s;
    logic [GW:0]         win_sum_s, win_full_s, g_sum_s;
    logic                win_vld_s;
    logic [ADDR_W-1:0]   n_win_s;
    logic [DW-1:0]       wsel_s;
    logic [CW-1:0]       n_ext_s, cnt_inc_s;
    logic [TW-1:0]       tmo_inc_s;

    // Winner search: rotate requests so the pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot_s = NUM_REQ'({bus.req_pi, bus.req_pi} >> ptr_q);
        win_vld_s = |bus.req_pi;
        off_s     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot_s[i]) begin
                off_s = GW'(i);
            end else begin
                off_s = off_s;
            end
        end
        win_sum_s  = {1'b0, ptr_q} + {1'b0, off_s};
        win_full_s = (win_sum_s >= NR_W) ? (win_sum_s - NR_W) : win_sum_s;
        win_s      = win_full_s[GW-1:0];
        g_sum_s    = {1'b0, g_q} + {{GW{1'b0}}, 1'b1};
        next_g_s   = (g_sum_s == NR_W) ? '0 : g_sum_s[GW-1:0];
    end

    // Per-requester muxes for the winner's word count and the granted requester's TX word.
    always_comb begin
        n_win_s = '0;
        wsel_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == GW'(i)) begin
                n_win_s = bus.n_tx_end_pi[i*ADDR_W +: ADDR_W];
            end else begin
                n_win_s = n_win_s;
            end
            if (g_q == GW'(i)) begin
                wsel_s = bus.wdata_pi[i*DW +: DW];
            end else begin
                wsel_s = wsel_s;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the cycle the FSM enters.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        gnt_d     = gnt_q;
        wd_ack_d  = '0;
        rvalid_d  = '0;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        spi_wr_d  = 1'b0;
        reg_sel_d = 1'b0;
        addr_d    = '0;
        entrada_d = '0;
        n_ext_s   = {1'b0, n_q};
        cnt_inc_s = cnt_q + CNT_ONE;
        tmo_inc_s = tmo_q + TMO_ONE;
        case (state_q)
            S_IDLE: begin
                if (win_vld_s) begin
                    state_d  = S_LOAD;
                    g_d      = win_s;
                    n_d      = n_win_s;
                    gnt_d    = ONE_R << win_s;
                    wd_ack_d = ONE_R << win_s;
                    cnt_d    = '0;
                    spi_wr_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                spi_wr_d = 1'b1;
                if (cnt_q == n_ext_s) begin
                    state_d   = S_CTRL;
                    reg_sel_d = 1'b1;
                    entrada_d = ctrl_word(n_q);
                end else begin
                    cnt_d    = cnt_inc_s;
                    addr_d   = cnt_inc_s[ADDR_W-1:0];
                    wd_ack_d = gnt_q;
                end
            end
            S_CTRL: begin
                state_d   = S_WAIT;
                reg_sel_d = 1'b1;
                tmo_d     = '0;
            end
            S_WAIT: begin
                reg_sel_d = 1'b1;
                tmo_d     = tmo_inc_s;
                // The first WAIT cycle may still see a stale send bit, so it is never trusted.
                if ((tmo_q != '0) && !bus.spi_salida_pi[0]) begin
                    state_d   = S_READ;
                    reg_sel_d = 1'b0;
                    cnt_d     = '0;
                end else if (tmo_inc_s == TMO_LIM) begin
                    state_d   = S_ABORT;
                    spi_wr_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_READ: begin
                cnt_d = cnt_inc_s;
                if (cnt_q == n_ext_s + CNT_ONE) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else begin
                    rdata_d  = bus.spi_salida_pi;
                    rvalid_d = gnt_q;
                    addr_d   = (cnt_q == n_ext_s) ? '0 : cnt_inc_s[ADDR_W-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = next_g_s;
            end
            S_ABORT: begin
                state_d = S_ERR;
                err_d   = gnt_q;
            end
            S_ERR: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = next_g_s;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            gnt_q     <= '0;
            wd_ack_q  <= '0;
            rvalid_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            spi_wr_q  <= 1'b0;
            reg_sel_q <= 1'b0;
            addr_q    <= '0;
            entrada_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            gnt_q     <= gnt_d;
            wd_ack_q  <= wd_ack_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            spi_wr_q  <= spi_wr_d;
            reg_sel_q <= reg_sel_d;
            addr_q    <= addr_d;
            entrada_q <= entrada_d;
            rdata_q   <= rdata_d;
        end
    end

    // During LOAD the requester's word passes straight through so it can advance one word per cycle.
    assign bus.spi_entrada_po = (state_q == S_LOAD) ? wsel_s : entrada_q;
    assign bus.gnt_po         = gnt_q;
    assign bus.wd_ack_po      = wd_ack_q;
    assign bus.rvalid_po      = rvalid_q;
    assign bus.rdata_po       = rdata_q;
    assign bus.done_po        = done_q;
    assign bus.err_po         = err_q;
    assign bus.busy_po        = busy_q;
    assign bus.spi_wr_po      = spi_wr_q;
    assign bus.spi_reg_sel_po = reg_sel_q;
    assign bus.spi_addr_po    = addr_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a loopback SPI register model and registered requesters.
module tb_spi_txn_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TMO = 100;

    typedef struct {
        int          id;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        bit          hang;
        bit          drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.NUM_REQ(NR), .DW(DW), .ADDR_W(AW)) bus_if ();

    spi_txn_arbiter #(.NUM_REQ(NR), .DW(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk_pi   (clk),
        .rst_n_pi (rst_n),
        .bus      (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0]  req;
    logic [3:0]  n_cfg [0:3];
    logic [31:0] words [0:3][0:255];
    logic [7:0]  widx  [0:3] = '{default: 8'd0};
    bit          hang_mode = 1'b0;
    logic [31:0] mem [0:15];
    logic [31:0] ctrl_r;
    int          send_cd = 0;

    assign bus_if.req_pi        = req;
    assign bus_if.spi_salida_pi = bus_if.spi_reg_sel_po ? ctrl_r : mem[bus_if.spi_addr_po];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus_if.wdata_pi[i*DW +: DW]    = words[i][widx[i]];
            bus_if.n_tx_end_pi[i*AW +: AW] = n_cfg[i];
        end
    end

    // Requesters present their next word the cycle after wd_ack.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (bus_if.wd_ack_po[i]) widx[i] <= widx[i] + 8'd1;
    end

    // SPI register model: loopback data memory; send self-clears 5 cycles after a kick unless hanging.
    always @(posedge clk) begin
        if (bus_if.spi_wr_po) begin
            if (bus_if.spi_reg_sel_po) begin
                ctrl_r  <= bus_if.spi_entrada_po;
                send_cd <= (bus_if.spi_entrada_po[0] && !hang_mode) ? 5 : 0;
            end else begin
                mem[bus_if.spi_addr_po] <= bus_if.spi_entrada_po;
            end
        end else if (send_cd != 0) begin
            send_cd <= send_cd - 1;
            if (send_cd == 1) ctrl_r[0] <= 1'b0;
        end
    end

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    logic [36:0] wr_log [0:511];
    logic [8:0]  wr_n = 9'd0;
    logic [33:0] rv_log [0:511];
    logic [8:0]  rv_n = 9'd0;
    int          done_n = 0, err_n = 0, wait_cnt = 0;
    logic [1:0]  last_done = 2'd0, last_err = 2'd0;
    logic [1:0]  gseq [0:31];
    logic [4:0]  gs_n = 5'd0;
    logic [3:0]  prev_gnt = 4'd0;
    bit          ovl_bad = 1'b0, rv_bad = 1'b0;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_if.spi_wr_po) begin
            wr_log[wr_n] <= {bus_if.spi_reg_sel_po, bus_if.spi_addr_po, bus_if.spi_entrada_po};
            wr_n         <= wr_n + 9'd1;
        end
        if (|bus_if.rvalid_po) begin
            rv_log[rv_n] <= {enc4(bus_if.rvalid_po), bus_if.rdata_po};
            rv_n         <= rv_n + 9'd1;
        end
        if ((bus_if.rvalid_po & ~bus_if.gnt_po) != 4'd0) rv_bad <= 1'b1;
        if (|bus_if.done_po) begin done_n <= done_n + 1; last_done <= enc4(bus_if.done_po); end
        if (|bus_if.err_po)  begin err_n  <= err_n + 1;  last_err  <= enc4(bus_if.err_po);  end
        if (!$onehot0(bus_if.gnt_po)) ovl_bad <= 1'b1;
        if (bus_if.gnt_po != 4'd0 && prev_gnt == 4'd0) begin
            gseq[gs_n] <= enc4(bus_if.gnt_po);
            gs_n       <= gs_n + 5'd1;
        end
        prev_gnt <= bus_if.gnt_po;
        if (bus_if.spi_reg_sel_po && !bus_if.spi_wr_po) wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bus_if.gnt_po, bus_if.wd_ack_po, bus_if.rvalid_po, bus_if.done_po,
                                bus_if.err_po, bus_if.busy_po, bus_if.spi_wr_po,
                                bus_if.spi_reg_sel_po, bus_if.spi_addr_po}), 64'd0);
        chk({tag, "_entrada"}, 64'(bus_if.spi_entrada_po), 64'd0);
        chk({tag, "_rdata"}, 64'(bus_if.rdata_po), 64'd0);
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int k);
        case (k)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return 32'hC0DE_0000 | (32'(v.id) << 8) | 32'(k);
        endcase
    endfunction

    function automatic logic [31:0] exp_ctrl(input int n);
        return (32'(n) << 4) | 32'h1;
    endfunction

    task automatic run_txn(input int vi, input vec_t v);
        logic [8:0] w0, r0;
        int d0, e0, wt0, cyc;
        bit fin;
        logic [7:0] base;
        base = widx[v.id];
        for (int k = 0; k <= v.n; k++) words[v.id][base + 8'(k)] = word_of(v, k);
        n_cfg[v.id] = 4'(v.n);
        hang_mode   = v.hang;
        w0 = wr_n; r0 = rv_n; d0 = done_n; e0 = err_n; wt0 = wait_cnt;
        req[v.id] = 1'b1;
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
            if (v.drop && bus_if.spi_reg_sel_po && !bus_if.spi_wr_po) req[v.id] = 1'b0;
            if (bus_if.done_po[v.id] || bus_if.err_po[v.id]) begin
                req[v.id] = 1'b0;
                fin = 1'b1;
            end
        end
        chk($sformatf("v%0d_finished", vi), 64'(fin), 64'd1);
        @(negedge clk);
        #1;
        for (int k = 0; k <= v.n; k++)
            chk($sformatf("v%0d_wr%0d", vi, k), 64'(wr_log[w0 + 9'(k)]),
                64'({1'b0, 4'(k), word_of(v, k)}));
        chk($sformatf("v%0d_ctrl", vi), 64'(wr_log[w0 + 9'(v.n + 1)]), 64'({1'b1, 4'd0, exp_ctrl(v.n)}));
        if (v.hang) begin
            chk($sformatf("v%0d_abort_wr", vi), 64'(wr_log[w0 + 9'(v.n + 2)]), 64'({1'b1, 4'd0, 32'd0}));
            chk($sformatf("v%0d_wr_cnt", vi), 64'(wr_n - w0), 64'(v.n + 3));
            chk($sformatf("v%0d_wait_cycles", vi), 64'(wait_cnt - wt0), 64'(TMO));
            chk($sformatf("v%0d_err_cnt", vi), 64'(err_n - e0), 64'd1);
            chk($sformatf("v%0d_err_id", vi), 64'(last_err), 64'(v.id));
            chk($sformatf("v%0d_rv_cnt", vi), 64'(rv_n - r0), 64'd0);
            chk($sformatf("v%0d_done_cnt", vi), 64'(done_n - d0), 64'd0);
        end else begin
            chk($sformatf("v%0d_wr_cnt", vi), 64'(wr_n - w0), 64'(v.n + 2));
            chk($sformatf("v%0d_rv_cnt", vi), 64'(rv_n - r0), 64'(v.n + 1));
            for (int k = 0; k <= v.n; k++)
                chk($sformatf("v%0d_rv%0d", vi, k), 64'(rv_log[r0 + 9'(k)]), 64'({2'(v.id), word_of(v, k)}));
            chk($sformatf("v%0d_done_cnt", vi), 64'(done_n - d0), 64'd1);
            chk($sformatf("v%0d_done_id", vi), 64'(last_done), 64'(v.id));
            chk($sformatf("v%0d_err_cnt", vi), 64'(err_n - e0), 64'd0);
        end
        chk($sformatf("v%0d_idle_gnt_busy", vi), 64'({bus_if.gnt_po, bus_if.busy_po}), 64'd0);
        hang_mode = 1'b0;
    endtask

    vec_t vecs [0:5];

    initial begin
        logic [4:0] g0;
        int d0, e0, cyc;
        bit found;
        vecs[0] = '{0, 2,  32'h0000_00A5, 32'h0000_003C, 32'h0000_0017, 1'b0, 1'b0};
        vecs[1] = '{1, 0,  32'h5A5A_0001, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[2] = '{3, 15, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 1'b0, 1'b0};
        vecs[3] = '{2, 3,  32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 1'b1, 1'b0};
        vecs[4] = '{0, 1,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0,         1'b0, 1'b0};
        vecs[5] = '{1, 4,  32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 1'b0, 1'b1};

        rst_n = 1'b0;
        req   = 4'd0;
        for (int i = 0; i < NR; i++) n_cfg[i] = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero("reset");

        // Fairness: all four request at once, each drops its request on its done pulse.
        for (int i = 0; i < NR; i++) begin
            n_cfg[i] = 4'd1;
            for (int k = 0; k < 8; k++) words[i][widx[i] + 8'(k)] = 32'h00F0_0000 | (32'(i) << 8) | 32'(k);
        end
        g0  = gs_n;
        d0  = done_n;
        req = 4'b1111;
        cyc = 0;
        while ((done_n - d0) < 4 && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NR; i++) if (bus_if.done_po[i]) req[i] = 1'b0;
        end
        chk("fair_done4", 64'(done_n - d0), 64'd4);
        req = 4'b1001;
        cyc = 0;
        while ((done_n - d0) < 6 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NR; i++) if (bus_if.done_po[i]) req[i] = 1'b0;
        end
        chk("fair_done6", 64'(done_n - d0), 64'd6);
        chk("fair_g0", 64'(gseq[g0 + 5'd0]), 64'd0);
        chk("fair_g1", 64'(gseq[g0 + 5'd1]), 64'd1);
        chk("fair_g2", 64'(gseq[g0 + 5'd2]), 64'd2);
        chk("fair_g3", 64'(gseq[g0 + 5'd3]), 64'd3);
        chk("fair_wrap_g0", 64'(gseq[g0 + 5'd4]), 64'd0);
        chk("fair_wrap_g3", 64'(gseq[g0 + 5'd5]), 64'd3);
        chk("fair_gnt_count", 64'(gs_n - g0), 64'd6);
        repeat (2) @(negedge clk);

        for (int vi = 0; vi < 6; vi++) run_txn(vi, vecs[vi]);

        // Asynchronous reset in the middle of LOAD at k=1.
        for (int k = 0; k < 8; k++) words[0][widx[0] + 8'(k)] = 32'h7700_0000 | 32'(k);
        n_cfg[0] = 4'd5;
        req[0]   = 1'b1;
        found    = 1'b0;
        cyc      = 0;
        while (!found && cyc < 50) begin
            @(negedge clk);
            cyc++;
            found = bus_if.spi_wr_po && !bus_if.spi_reg_sel_po && (bus_if.spi_addr_po == 4'd1);
        end
        chk("rst_reached_k1", 64'(found), 64'd1);
        d0 = done_n;
        e0 = err_n;
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_no_done_err", 64'({32'(done_n - d0), 32'(err_n - e0)}), 64'd0);
        run_txn(6, '{2, 1, 32'h2222_0000, 32'h2222_0001, 32'h0, 1'b0, 1'b0});

        chk("gnt_never_overlap", 64'(ovl_bad), 64'd0);
        chk("rvalid_only_granted", 64'(rv_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
